// File: rtl/phoenix_input_buffer.sv
// phoenix_input_buffer: per-port flit FIFO and packet sequencer of the Phoenix router.
// Incoming flits are stored under credit flow control. When a header reaches the FIFO
// head, h requests routing. After ack_h the header, the size flit and the payload are
// streamed to the crossbar. sender is held high for the whole packet.
//
// Ports:
//   clock     - sole clock, rising edge
//   reset     - asynchronous, active-low reset
//   rx        - upstream flit valid
//   data_in   - upstream flit
//   credit_o  - upstream may send (FIFO not full)
//   h         - routing request to switch control
//   ack_h     - routing granted (single-cycle pulse)
//   data_av   - flit valid toward crossbar
//   data      - flit at FIFO head
//   data_ack  - crossbar consumed data this cycle
//   sender    - packet in transit through this port
module phoenix_input_buffer #(
  parameter int unsigned TAM_FLIT   = 16,
  parameter int unsigned TAM_BUFFER = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic [TAM_FLIT-1:0] data_in,
  output logic                credit_o,
  output logic                h,
  input  logic                ack_h,
  output logic                data_av,
  output logic [TAM_FLIT-1:0] data,
  input  logic                data_ack,
  output logic                sender
);

  localparam int unsigned PtrW = $clog2(TAM_BUFFER);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  localparam cnt_t CountFull = cnt_t'(TAM_BUFFER);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHeader,
    StSize,
    StPayload,
    StEnd
  } state_e;

  state_e              state_q, state_d;
  logic [TAM_FLIT-1:0] buf_q [TAM_BUFFER];
  ptr_t                first_q, last_q;
  cnt_t                count_q, count_d;
  logic [TAM_FLIT-1:0] remaining_q, remaining_d;
  logic                push, pop, streaming;

  // Credit comes from the registered count only; a same-cycle pop does not reopen it.
  assign credit_o = (count_q != CountFull);
  assign push     = rx && credit_o;
  assign pop      = data_av && data_ack;
  assign data     = buf_q[first_q];

  // Storage contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_q[last_q] <= data_in;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q <= '0;
      last_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        last_q <= last_q + ptr_t'(1);
      end
      if (pop) begin
        first_q <= first_q + ptr_t'(1);
      end
      count_q <= count_d;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack_h) begin
          state_d = StHeader;
        end
      end
      StHeader: begin
        if (pop) begin
          state_d = StSize;
        end
      end
      StSize: begin
        if (pop) begin
          remaining_d = data;
          state_d     = (data == '0) ? StEnd : StPayload;
        end
      end
      StPayload: begin
        if (pop) begin
          remaining_d = remaining_q - TAM_FLIT'(1);
          if (remaining_q == TAM_FLIT'(1)) begin
            state_d = StEnd;
          end
        end
      end
      StEnd: begin
        // One-cycle gap with sender low gives switch control its falling edge.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode
  always_comb begin
    h         = 1'b0;
    streaming = 1'b0;
    unique case (state_q)
      StReq:                         h         = 1'b1;
      StHeader, StSize, StPayload:   streaming = 1'b1;
      default:                       streaming = 1'b0;
    endcase
    sender  = streaming;
    data_av = streaming && (count_q != '0);
  end

endmodule

// File: tb/tb_phoenix_input_buffer.sv
// tb_phoenix_input_buffer: directed and randomized checks of phoenix_input_buffer against a
// packet-level reference model (a flit queue plus a packet phase).
module tb_phoenix_input_buffer;

  localparam int W = 16;
  localparam int D = 4;

  logic         clock    = 1'b0;
  logic         reset    = 1'b1;
  logic         rx       = 1'b0;
  logic         ack_h    = 1'b0;
  logic         data_ack = 1'b0;
  logic [W-1:0] data_in  = '0;
  logic         credit_o, h, data_av, sender;
  logic [W-1:0] data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  phoenix_input_buffer #(
    .TAM_FLIT   (W),
    .TAM_BUFFER (D)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data_in  (data_in),
    .credit_o (credit_o),
    .h        (h),
    .ack_h    (ack_h),
    .data_av  (data_av),
    .data     (data),
    .data_ack (data_ack),
    .sender   (sender)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, packet handling as four coarse phases.
  typedef enum int {MIdle, MReq, MStream, MEnd} mphase_e;
  mphase_e      m_phase = MIdle;
  logic [W-1:0] m_q[$];
  int           m_popped = 0;
  int           m_total  = 0;
  bit           m_pushed = 1'b0;
  bit           m_pop;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_phase  = MIdle;
      m_popped = 0;
      m_total  = 0;
      m_pushed = 1'b0;
    end else begin
      m_pop    = (m_phase == MStream) && (m_q.size() != 0) && data_ack;
      m_pushed = rx && (m_q.size() != D);
      case (m_phase)
        MIdle:   if (m_q.size() != 0) m_phase = MReq;
        MReq:    if (ack_h) begin m_phase = MStream; m_popped = 0; end
        MStream: begin
          if (m_pop) begin
            if (m_popped == 1) m_total = int'(m_q[0]) + 2;
            m_popped++;
            if (m_popped >= 2 && m_popped == m_total) m_phase = MEnd;
          end
        end
        default: m_phase = MIdle;
      endcase
      if (m_pop) void'(m_q.pop_front());
      if (m_pushed) m_q.push_back(data_in);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check1("credit_o", credit_o, m_q.size() != D);
      check1("h", h, m_phase == MReq);
      check1("sender", sender, m_phase == MStream);
      check1("data_av", data_av, (m_phase == MStream) && (m_q.size() != 0));
      if ((m_phase == MStream) && (m_q.size() != 0)) checkw("data", data, m_q[0]);
    end
  end

  // Pushes pk on consecutive cycles, grants after h has been high ack_delay cycles, holds
  // data_ack high and records what the crossbar sees.
  task automatic run_packet(input logic [W-1:0] pk[$], input int ack_delay, input int ncyc,
                            output logic [W-1:0] got[$], output int first_h,
                            output int s_total, output int s_run, output logic h_at_end);
    int hcnt = 0;
    int idx  = 0;
    bit in_run = 1'b0;
    bit run_done = 1'b0;
    got.delete();
    first_h  = -1;
    s_total  = 0;
    s_run    = 0;
    h_at_end = 1'b1;
    data_ack = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      if (data_av) got.push_back(data);
      if (sender) begin
        s_total++;
        if (!run_done) s_run++;
        in_run = 1'b1;
      end else if (in_run && !run_done) begin
        run_done = 1'b1;
        h_at_end = h;
      end
      if (h) begin
        if (first_h < 0) first_h = c;
        hcnt++;
      end else begin
        hcnt = 0;
      end
      ack_h = h && (hcnt >= ack_delay);
      if (idx < pk.size()) begin
        rx      = 1'b1;
        data_in = pk[idx];
        idx++;
      end else begin
        rx = 1'b0;
      end
    end
    rx    = 1'b0;
    ack_h = 1'b0;
  endtask

  logic [W-1:0] gen_q[$];

  task automatic make_packet(input int n);
    gen_q.push_back(W'($urandom));
    gen_q.push_back(W'(n));
    for (int i = 0; i < n; i++) gen_q.push_back(W'($urandom));
  endtask

  logic [W-1:0] pk[$];
  logic [W-1:0] got[$];
  int           first_h, s_total, s_run, idx;
  logic         h_at_end;
  bit           found;
  bit           first_pkt;

  initial begin
    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    check1("rst_h", h, 1'b0);
    check1("rst_sender", sender, 1'b0);
    check1("rst_data_av", data_av, 1'b0);
    check1("rst_credit", credit_o, 1'b1);
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check1("post_rst_h", h, 1'b0);
    check1("post_rst_sender", sender, 1'b0);
    check1("post_rst_credit", credit_o, 1'b1);

    // Single packet, grant three cycles into the request
    pk.delete();
    pk.push_back(16'h0011); pk.push_back(16'h0002);
    pk.push_back(16'hAAAA); pk.push_back(16'hBBBB);
    run_packet(pk, 3, 16, got, first_h, s_total, s_run, h_at_end);
    checki("single_len", got.size(), 4);
    checkw("single_d0", got[0], 16'h0011);
    checkw("single_d1", got[1], 16'h0002);
    checkw("single_d2", got[2], 16'hAAAA);
    checkw("single_d3", got[3], 16'hBBBB);
    checki("single_first_h", first_h, 2);
    checki("single_sender_cycles", s_total, 4);
    checki("single_sender_run", s_run, 4);
    check1("single_h_in_end", h_at_end, 1'b0);

    // Full FIFO and backpressure
    pk.delete();
    pk.push_back(16'h0044); pk.push_back(16'h0002); pk.push_back(16'h00D1);
    pk.push_back(16'h00D2); pk.push_back(16'h00E5); pk.push_back(16'h00E6);
    data_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      rx      = 1'b1;
      data_in = pk[i];
      @(negedge clock);
      check1("bp_credit", credit_o, (i < 4) ? 1'b1 : 1'b0);
    end
    @(posedge clock);
    #1;
    rx = 1'b0;
    @(negedge clock);
    check1("bp_full_credit", credit_o, 1'b0);
    check1("bp_full_h", h, 1'b1);
    @(posedge clock);
    #1;
    ack_h = 1'b1;
    @(posedge clock);
    #1;
    ack_h    = 1'b0;
    data_ack = 1'b1;
    @(negedge clock);
    checkw("bp_head", data, 16'h0044);
    check1("bp_av", data_av, 1'b1);
    check1("bp_no_early_credit", credit_o, 1'b0);
    @(posedge clock);
    #1;
    data_ack = 1'b0;
    @(negedge clock);
    check1("bp_credit_back", credit_o, 1'b1);
    checkw("bp_size", data, 16'h0002);
    data_ack = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (!sender) found = 1'b1;
    end
    check1("bp_drain_done", found, 1'b1);
    repeat (4) @(negedge clock);
    check1("bp_dropped_h", h, 1'b0);
    check1("bp_dropped_av", data_av, 1'b0);

    // Zero-length packet followed back-to-back by a one-flit packet
    pk.delete();
    pk.push_back(16'h0022); pk.push_back(16'h0000); pk.push_back(16'h0033);
    pk.push_back(16'h0001); pk.push_back(16'hCCCC);
    run_packet(pk, 1, 24, got, first_h, s_total, s_run, h_at_end);
    checki("b2b_len", got.size(), 5);
    checkw("b2b_d0", got[0], 16'h0022);
    checkw("b2b_d1", got[1], 16'h0000);
    checkw("b2b_d2", got[2], 16'h0033);
    checkw("b2b_d3", got[3], 16'h0001);
    checkw("b2b_d4", got[4], 16'hCCCC);
    checki("b2b_first_run", s_run, 2);
    checki("b2b_sender_cycles", s_total, 5);
    check1("b2b_h_in_end", h_at_end, 1'b0);

    // Reset after the size flit has been consumed
    pk.delete();
    pk.push_back(16'h0055); pk.push_back(16'h0003); pk.push_back(16'h0101);
    pk.push_back(16'h0102); pk.push_back(16'h0103);
    idx      = 0;
    found    = 1'b0;
    data_ack = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clock);
      #1;
      if (data_av && data == 16'h0003) found = 1'b1;
      ack_h = h;
      if (idx < pk.size()) begin
        rx      = 1'b1;
        data_in = pk[idx];
        idx++;
      end else begin
        rx = 1'b0;
      end
    end
    check1("rstmid_size_seen", found, 1'b1);
    @(posedge clock);
    #2;
    reset = 1'b0;
    rx    = 1'b0;
    ack_h = 1'b0;
    #1;
    check1("rstmid_sender", sender, 1'b0);
    check1("rstmid_data_av", data_av, 1'b0);
    check1("rstmid_credit", credit_o, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check1("rstmid_empty_h", h, 1'b0);
    pk.delete();
    pk.push_back(16'h0066); pk.push_back(16'h0001); pk.push_back(16'h0077);
    run_packet(pk, 1, 16, got, first_h, s_total, s_run, h_at_end);
    checki("rstmid_new_len", got.size(), 3);
    checkw("rstmid_new_d0", got[0], 16'h0066);
    checkw("rstmid_new_d1", got[1], 16'h0001);
    checkw("rstmid_new_d2", got[2], 16'h0077);
    checki("rstmid_new_sender", s_total, 3);

    // Randomized traffic; opens with a size-8 packet under alternating data_ack
    gen_q.delete();
    first_pkt = 1'b1;
    rx = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      if (rx && m_pushed) void'(gen_q.pop_front());
      if (gen_q.size() == 0) begin
        make_packet(first_pkt ? 8 : int'($urandom_range(0, 5)));
        first_pkt = 1'b0;
      end
      rx       = ($urandom_range(0, 9) < 7);
      data_in  = gen_q[0];
      ack_h    = ($urandom_range(0, 3) == 0);
      data_ack = (c < 300) ? ((c % 2) == 0) : ($urandom_range(0, 9) < 6);
    end
    rx       = 1'b0;
    ack_h    = 1'b1;
    data_ack = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    ack_h = 1'b0;
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
